prime_scan_controller: RTL and testbench

- Sequences the prime-detector datapath from a single system clock.
- An internal divider produces a one-cycle seconds tick (an enable, not a derived clock).
- Each tick advances the candidate by one and runs a multi-cycle trial-division primality check.
- Results are presented as stable registered values for the seconds/number display.

---
 rtl/prime_scan_controller.sv | 127 ++++++++++++
 tb/tb_prime_scan_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prime_scan_controller.sv
// Prime scan controller: a seconds-tick divider plus a trial-division FSM that
// tests successive candidates and presents each result as stable registered outputs.
module prime_scan_controller #(
    parameter int DIV   = 10000000,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    output logic [WIDTH-1:0] candidate,
    output logic             is_prime,
    output logic             result_valid,
    output logic             busy,
    output logic             sec_tick,
    output logic             overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = 2 * WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SUB, NEXT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   d;
    logic             flag;
    logic             start;
    logic             rem_ge_d;
    logic [WIDTH:0]   d_inc;
    logic [PW-1:0]    d_sq;

    // The tick is decoded from the registered count, so a run change mid-cycle
    // only takes effect at the next edge.
    assign sec_tick = (count == LAST);
    assign start    = sec_tick || (step && !run);
    assign busy     = (state != IDLE);
    assign rem_ge_d = ({1'b0, rem} >= d);
    assign d_inc    = d + 1'b1;
    assign d_sq     = PW'(d_inc) * PW'(d_inc);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || sec_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (n <= WIDTH'(3)) ? DONE : SUB;
            SUB: begin
                if (rem_ge_d)        state_nxt = SUB;
                else if (rem == '0)  state_nxt = DONE;
                else                 state_nxt = NEXT;
            end
            NEXT: state_nxt = (d_sq > PW'(n)) ? DONE : SUB;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n            <= '0;
            rem          <= '0;
            d            <= '0;
            flag         <= 1'b0;
            candidate    <= '0;
            is_prime     <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= (state == DONE);
            // Ticks seen outside IDLE (including DONE) are dropped, never queued.
            if (sec_tick && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (start) n <= candidate + 1'b1;
                LOAD: begin
                    if (n < WIDTH'(2)) begin
                        flag <= 1'b0;
                    end else if (n <= WIDTH'(3)) begin
                        flag <= 1'b1;
                    end else begin
                        d   <= (WIDTH + 1)'(2);
                        rem <= n;
                    end
                end
                SUB: begin
                    if (rem_ge_d)       rem  <= rem - d[WIDTH-1:0];
                    else if (rem == '0) flag <= 1'b0;
                end
                NEXT: begin
                    d <= d_inc;
                    if (d_sq > PW'(n)) flag <= 1'b1;
                    else               rem  <= n;
                end
                DONE: begin
                    candidate <= n;
                    is_prime  <= flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scan_controller.sv
// Scoreboard bench for prime_scan_controller: expected results are queued when a
// start is driven and popped whenever result_valid pulses.
module tb_prime_scan_controller;

    localparam int DIV    = 10;
    localparam int WIDTH  = 8;
    localparam int BUDGET = 3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [WIDTH-1:0] candidate;
    logic             is_prime;
    logic             result_valid;
    logic             busy;
    logic             sec_tick;
    logic             overrun;

    typedef struct {
        logic [WIDTH-1:0] cand;
        logic             prime;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   model_cand = 0;

    prime_scan_controller #(.DIV(DIV), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .candidate   (candidate),
        .is_prime    (is_prime),
        .result_valid(result_valid),
        .busy        (busy),
        .sec_tick    (sec_tick),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic model_prime(input int v);
        if (v < 2) return 1'b0;
        for (int q = 2; q * q <= v; q++)
            if (v % q == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_next();
        exp_t e;
        model_cand = (model_cand + 1) % (1 << WIDTH);
        e.cand  = model_cand[WIDTH-1:0];
        e.prime = model_prime(model_cand);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("candidate", candidate, e.cand);
                check("is_prime", is_prime, e.prime);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_tick(output int edges);
        edges = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            edges++;
            if (sec_tick) return;
        end
        check("tick_timeout", sec_tick, 1);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic step_to(input int target);
        while (model_cand != target) begin
            push_next();
            pulse_step();
            wait_idle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_candidate"}, candidate, 0);
        check({tag, "_is_prime"}, is_prime, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sec_tick"}, sec_tick, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int e;
        int last_t;
        int ticks;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Free-running ticks: results 1..5, spacing DIV, latency 3 for n<4.
        run = 1'b1;
        last_t = 0;
        for (int k = 1; k <= 5; k++) begin
            push_next();
            wait_tick(e);
            if (k == 1) check("first_tick_delay", e, DIV - 1);
            else        check("tick_spacing", cyc - last_t, DIV);
            last_t = cyc;
            if (k == 5) begin
                run = 1'b0;
            end else if (k <= 3) begin
                repeat (3) @(negedge clk);
                check("latency_rv", result_valid, 1);
            end
        end
        wait_idle();

        // Paused stepping, including a step ignored while busy.
        step_to(8);
        step_to(11);
        step_to(25);
        step_to(96);
        push_next();
        pulse_step();
        repeat (5) @(negedge clk);
        check("busy_97", busy, 1);
        pulse_step();
        wait_idle();
        repeat (3) @(negedge clk);
        check("no_extra_result", exp_q.size(), 0);
        check("cand_97", candidate, 97);

        // Overrun: ticks land while 251 is being searched.
        step_to(250);
        check("overrun_clear", overrun, 0);
        run = 1'b1;
        push_next();
        for (int i = 0; i < BUDGET && !overrun; i++) @(negedge clk);
        check("overrun_set", overrun, 1);
        check("busy_at_overrun", busy, 1);
        run = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("overrun_sticky", overrun, 1);
        check("cand_251", candidate, 251);
        ticks = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (sec_tick) ticks++;
        end
        check("tick_paused", ticks, 0);
        check("count_held", dut.count, 0);
        run = 1'b1;
        push_next();
        wait_tick(e);
        run = 1'b0;
        check("resume_delay", e, DIV - 1);
        wait_idle();

        // Wrap-around at the top of the candidate range.
        step_to(254);
        push_next();
        pulse_step();
        wait_idle();
        push_next();
        pulse_step();
        wait_idle();
        @(negedge clk);
        check("wrap_cand", candidate, 0);
        check("no_x", $isunknown({candidate, is_prime, result_valid, busy, sec_tick, overrun}), 0);

        // Reset in the middle of the 97 search.
        step_to(96);
        pulse_step();
        repeat (10) @(negedge clk);
        check("busy_mid_sub", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_cand = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        push_next();
        wait_tick(e);
        run = 1'b0;
        check("post_reset_tick_delay", e, DIV - 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("post_reset_cand", candidate, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
